// File: rtl/fp_mul_seq_param.sv
// -----------------------------------------------------------------------------
// fp_mul_seq_param
//   Sequential IEEE-754-style floating-point multiplier with generic exponent
//   and mantissa widths. A shift-add mantissa datapath (one multiplier bit per
//   cycle) sits behind a start/done handshake.
//   Zero, infinity and NaN operands are resolved without running the multiply.
//   Denormal operands are flushed to zero.
//   Out-of-range exponents saturate to signed infinity or signed zero.
//
//   Build option:
//     FP_MUL_RNE_EN  defined   -> round to nearest, ties to even
//                    undefined -> truncate (round toward zero)
//     Latency is identical in both builds.
//
// Parameters
//   EXP_W  exponent field width (bias = 2^(EXP_W-1)-1)
//   MAN_W  stored mantissa width (hidden 1 implied)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous reset, active low
//   start  in   request, accepted only when idle and not busy
//   a, b   in   operands, captured on an accepted start
//   res    out  registered product, held until the next result is written
//   done   out  one-cycle pulse when res is updated
//   busy   out  high from the cycle after acceptance through the done cycle
// -----------------------------------------------------------------------------
module fp_mul_seq_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic [EXP_W+MAN_W:0] res,
    output logic                 done,
    output logic                 busy
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int M     = MAN_W + 1;       // mantissa width incl. hidden bit
    localparam int PW    = 2 * M;           // full product width
    localparam int EW    = EXP_W + 2;       // signed working exponent width
    localparam int CNT_W = $clog2(M);

    localparam logic signed [EW-1:0] BIAS_E = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic [W-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

`ifdef FP_MUL_RNE_EN
    localparam logic RNE_EN = 1'b1;
`else
    localparam logic RNE_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_MULT   = 3'd2;
    localparam logic [2:0] S_NORM   = 3'd3;
    localparam logic [2:0] S_ROUND  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]           state_q,  state_d;
    logic [W-1:0]         a_q,      a_d;
    logic [W-1:0]         b_q,      b_d;
    logic                 sign_q,   sign_d;
    logic signed [EW-1:0] exp_q,    exp_d;
    logic [M-1:0]         mcand_q,  mcand_d;
    logic [M-1:0]         mplier_q, mplier_d;
    logic [PW-1:0]        prod_q,   prod_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 sticky_q, sticky_d;
    logic [W-1:0]         result_q, result_d;
    logic [W-1:0]         res_q,    res_d;
    logic                 done_q,   done_d;
    logic                 busy_q,   busy_d;

    // Operand decode
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, accept;

    assign ea     = a_q[W-2:MAN_W];
    assign eb     = b_q[W-2:MAN_W];
    assign ma     = a_q[MAN_W-1:0];
    assign mb     = b_q[MAN_W-1:0];
    assign sgn    = a_q[W-1] ^ b_q[W-1];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (ma == '0);
    assign b_inf  = (eb == '1) && (mb == '0);
    assign a_nan  = (ea == '1) && (ma != '0);
    assign b_nan  = (eb == '1) && (mb != '0);

    // busy_q is still high in the done cycle, so a start there is ignored
    assign accept = (state_q == S_IDLE) && start && !busy_q;

    // Shift-add step: add multiplicand into the upper half, then shift the
    // whole accumulator right; after M steps it holds the full product.
    logic [M:0] acc_sum;
    assign acc_sum = {1'b0, prod_q[PW-1:M]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

    // Rounding on the normalised product (leading 1 at bit PW-2)
    logic [MAN_W-1:0]     man_keep, man_rnd;
    logic                 guard, sticky, inc;
    logic [MAN_W+1:0]     rnd;
    logic signed [EW-1:0] exp_rnd;

    assign man_keep = prod_q[PW-3 -: MAN_W];
    assign guard    = prod_q[MAN_W-1];
    assign sticky   = (|prod_q[MAN_W-2:0]) | sticky_q;
    assign inc      = RNE_EN & guard & (sticky | man_keep[0]);
    assign rnd      = {1'b0, 1'b1, man_keep} + {{(MAN_W+1){1'b0}}, inc};
    assign exp_rnd  = rnd[MAN_W+1] ? exp_q + ONE_E : exp_q;
    assign man_rnd  = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        result_d = result_q;
        res_d    = res_q;
        done_d   = (state_q == S_DONE);
        busy_d   = accept || (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sign_d   = sgn;
                exp_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;
                mcand_d  = {1'b1, ma};
                mplier_d = {1'b1, mb};
                prod_d   = '0;
                cnt_d    = '0;
                if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                    result_d = QNAN;
                    state_d  = S_DONE;
                end else if (a_inf || b_inf) begin
                    result_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    state_d  = S_DONE;
                end else if (a_zero || b_zero) begin
                    result_d = {sgn, {(W-1){1'b0}}};
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_MULT;
                end
            end
            S_MULT: begin
                prod_d   = {acc_sum, prod_q[M-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(M - 1)) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                // The bit shifted out is kept so rounding still sees it
                if (prod_q[PW-1]) begin
                    prod_d   = prod_q >> 1;
                    sticky_d = prod_q[0];
                    exp_d    = exp_q + ONE_E;
                end else begin
                    sticky_d = 1'b0;
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (exp_rnd >= EMAX_E) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (exp_rnd[EW-1] || (exp_rnd == '0)) begin
                    result_d = {sign_q, {(W-1){1'b0}}};
                end else begin
                    result_d = {sign_q, exp_rnd[EXP_W-1:0], man_rnd};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                res_d   = result_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            result_q <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            res_q    <= res_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign res  = res_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_fp_mul_seq_param.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_seq_param
//   Scoreboard bench for fp_mul_seq_param. The driver pushes the expected
//   result and completion cycle for each accepted operation; a monitor pops
//   and compares on every done pulse. Expected values come from directed
//   constants or from an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fp_mul_seq_param;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX  = (1 << EXP_W) - 1;
    localparam int LAT   = MAN_W + 5;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

`ifdef FP_MUL_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] res;
    logic         done;
    logic         busy;

    fp_mul_seq_param #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .res   (res),
        .done  (done),
        .busy  (busy)
    );

    typedef struct {
        logic [W-1:0] res;
        int           due;
        string        tag;
    } exp_t;

    exp_t sb[$];
    exp_t item;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Reference model: exact integer product, then round and range-limit
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             output int lat);
        logic s;
        int ex, ey, e, drop;
        longint unsigned mx, my, p, keep, rem, half;
        bit xz, yz, xi, yi, xn, yn;
        s  = x[W-1] ^ y[W-1];
        ex = int'(x[W-2:MAN_W]);
        ey = int'(y[W-2:MAN_W]);
        mx = 64'(x[MAN_W-1:0]);
        my = 64'(y[MAN_W-1:0]);
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == EMAX) && (mx == 0);
        yi = (ey == EMAX) && (my == 0);
        xn = (ex == EMAX) && (mx != 0);
        yn = (ey == EMAX) && (my != 0);
        lat = 2;
        if (xn || yn || (xi && yz) || (yi && xz)) return QNAN;
        if (xi || yi) return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        if (xz || yz) return {s, {(W-1){1'b0}}};
        lat  = LAT;
        p    = (mx + (64'd1 << MAN_W)) * (my + (64'd1 << MAN_W));
        e    = ex + ey - BIAS;
        drop = MAN_W;
        if (p >= (64'd1 << (2 * MAN_W + 1))) begin
            drop++;
            e++;
        end
        keep = p >> drop;
        rem  = p - (keep << drop);
        half = 64'd1 << (drop - 1);
        if (RNE && ((rem > half) || ((rem == half) && keep[0]))) keep++;
        if (keep >= (64'd1 << (MAN_W + 1))) begin
            keep = keep >> 1;
            e++;
        end
        if (e >= EMAX) return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        if (e <= 0) return {s, {(W-1){1'b0}}};
        return {s, EXP_W'(e), MAN_W'(keep)};
    endfunction

    function automatic logic [W-1:0] rnd_op();
        int unsigned r;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        r = $urandom_range(0, 9);
        m = MAN_W'($urandom);
        if (r == 0)      e = '0;
        else if (r == 1) e = '1;
        else if (r <= 3) e = EXP_W'($urandom_range(1, 20));
        else if (r <= 5) e = EXP_W'($urandom_range(EMAX - 20, EMAX - 1));
        else             e = EXP_W'($urandom_range(1, EMAX - 1));
        if ($urandom_range(0, 7) == 0) m = '0;
        return {1'($urandom), e, m};
    endfunction

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait_busy", W'(busy), '0);
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] expv, input int lat, input string tag);
        wait_idle();
        a_in  = x;
        b_in  = y;
        start = 1'b1;
        sb.push_back('{res: expv, due: cyc + 1 + lat, tag: tag});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with nothing outstanding, res=%h", res);
            end else begin
                item = sb.pop_front();
                chk({"result ", item.tag}, res, item.res);
                chk_int({"latency ", item.tag}, cyc, item.due);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d outstanding", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] x, y, ev, held;
        int lat;

        rst   = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        chk("reset_res", res, '0);
        chk("reset_done", W'(done), '0);
        chk("reset_busy", W'(busy), '0);
        rst = 1'b1;

        // Directed vectors
        issue(32'h3FC00000, 32'h40000000, 32'h40400000, LAT, "1.5*2.0");
        issue(32'h3F800800, 32'h3F800801, RNE ? 32'h3F801002 : 32'h3F801001, LAT, "rounding");
        issue(32'h7F800000, 32'h00000000, 32'h7FC00000, 2, "inf*0");
        issue(32'hFF800000, 32'h40000000, 32'hFF800000, 2, "-inf*2");
        issue(32'h7F000000, 32'h40000000, 32'h7F800000, LAT, "overflow");
        issue(32'h00800000, 32'h00800000, 32'h00000000, LAT, "underflow");
        ev = ref_mul(32'h416CA3D7, 32'hC2C4428F, lat);
        issue(32'h416CA3D7, 32'hC2C4428F, ev, lat, "14.79*-98.13");
        held = ev;

        // Start pulsed with junk operands while busy (and in the done cycle)
        issue(32'h40400000, 32'h40800000, 32'h41400000, LAT, "busy_ignore");
        begin
            int k = 0;
            while (!done && k < 60) begin
                chk("res_held_while_busy", res, held);
                start = 1'b1;
                a_in  = $urandom;
                b_in  = $urandom;
                @(negedge clk);
                k++;
            end
            @(negedge clk);
            start = 1'b0;
        end

        // Reset during MULT
        wait_idle();
        a_in  = 32'h3FC00000;
        b_in  = 32'h40000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_res", res, '0);
        chk("midreset_busy", W'(busy), '0);
        chk("midreset_done", W'(done), '0);
        @(negedge clk);
        rst = 1'b1;
        repeat (35) @(negedge clk);
        issue(32'h3FC00000, 32'h40000000, 32'h40400000, LAT, "after_reset");

        // Random operations, back to back
        for (int i = 0; i < 150; i++) begin
            x  = rnd_op();
            y  = rnd_op();
            ev = ref_mul(x, y, lat);
            issue(x, y, ev, lat, $sformatf("rand %h*%h", x, y));
        end

        begin
            int k = 0;
            while (sb.size() != 0 && k < 100) begin
                @(negedge clk);
                k++;
            end
            chk_int("drain_outstanding", sb.size(), 0);
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
